// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer and main control: state codes,
// error codes and the opcodes the sequencer is willing to execute.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ECALL   = 2'd3
    } err_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // True for opcodes that proceed to EXECUTE; SYSTEM is handled separately
    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Wait-cycle counter for the FETCH and MEM handshakes. expired flags the
// waiting cycle on which the count reaches MAX, so the caller can let a
// handshake on that same cycle take priority.
module wait_timer #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (MAX < 2) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] count;

    assign expired = tick && (count == CW'(MAX - 1));

    // Count waiting cycles; held at zero outside the waiting states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != CW'(MAX))) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: steps fetch/decode/execute/mem/writeback,
// owns the program counter and retired-instruction count, and halts on
// illegal opcodes, ECALL or handshake timeout.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | instruction memory enabled, waiting for instr_valid
// DECODE  | opcode check, ECALL / illegal go to HALT
// EXECUTE | route to MEM for loads/stores, else WB
// MEM     | data memory enabled, waiting for mem_ready
// WB      | register write strobe, pc and retired update
// HALT    | sticky until reset
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int WAIT_MAX = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            instr_valid,
    input  logic [6:0]      opcode,
    input  logic            branch,
    input  logic            zero,
    input  logic            memread,
    input  logic            memwrite,
    input  logic [31:0]     imm,
    input  logic            mem_ready,
    output logic [2:0]      phase,
    output logic [PC_W-1:0] pc,
    output logic            ifetch_en,
    output logic            dmem_en,
    output logic            rf_we_en,
    output logic            halted,
    output logic [1:0]      err,
    output logic [15:0]     retired
);

    state_t          state;
    err_t            err_q;
    logic            waiting;
    logic            handshake;
    logic            expired;
    logic [PC_W-1:0] pc_next;
    logic            imm_unused;

    assign phase     = state;
    assign err       = err_q;
    assign ifetch_en = (state == ST_FETCH);
    assign dmem_en   = (state == ST_MEM);
    assign rf_we_en  = (state == ST_WB);

    assign waiting   = (state == ST_FETCH) || (state == ST_MEM);
    assign handshake = ((state == ST_FETCH) && instr_valid) ||
                       ((state == ST_MEM) && mem_ready);

    // imm is a byte offset; only the word-offset bits that fit the pc matter
    assign pc_next    = (branch && zero) ? pc + imm[PC_W+1:2] : pc + PC_W'(1);
    assign imm_unused = ^{imm[31:PC_W+2], imm[1:0]};

    wait_timer #(.MAX(WAIT_MAX)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!waiting),
        .tick    (waiting && !handshake),
        .expired (expired)
    );

    // Sequencer state plus registered pc, retired, err and halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc      <= '0;
            retired <= '0;
            err_q   <= ERR_NONE;
            halted  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (instr_valid) begin
                        state <= ST_DECODE;
                    end else if (expired) begin
                        state  <= ST_HALT;
                        err_q  <= ERR_TIMEOUT;
                        halted <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (opcode == OP_SYSTEM) begin
                        state  <= ST_HALT;
                        err_q  <= ERR_ECALL;
                        halted <= 1'b1;
                    end else if (!is_legal_op(opcode)) begin
                        state  <= ST_HALT;
                        err_q  <= ERR_ILLEGAL;
                        halted <= 1'b1;
                    end else begin
                        state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    state <= (memread || memwrite) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state <= ST_WB;
                    end else if (expired) begin
                        state  <= ST_HALT;
                        err_q  <= ERR_TIMEOUT;
                        halted <= 1'b1;
                    end
                end
                ST_WB: begin
                    pc    <= pc_next;
                    state <= ST_FETCH;
                    if (retired != 16'hFFFF) retired <= retired + 16'd1;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
